// File: rtl/seq_pkg.sv
// Shared definitions for the sequence-detector side blocks: history width,
// logger FSM states and the default capture entry layout.
package seq_pkg;
  localparam int HIST_W   = 5;
  localparam int DEF_TS_W = 11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FROZEN = 2'd2
  } state_t;

  typedef struct packed {
    logic [DEF_TS_W-1:0] ts;
    logic [HIST_W-1:0]   hist;
  } entry_t;

  function automatic int entry_w(input int ts_w);
    return ts_w + HIST_W;
  endfunction
endpackage

// File: rtl/seq_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers carry an extra wrap bit
// so full and empty are distinguished without an occupancy counter.
module seq_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr, r_rptr;
  logic             w_do_pop, w_do_push;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = i_pop & ~o_empty;
  // a pop frees the slot in the same edge, so a full FIFO can still accept
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_dout    = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr[AW-1:0]] <= i_din;
        r_wptr                <= r_wptr + 1'b1;
      end
      if (w_do_pop) r_rptr <= r_rptr + 1'b1;
    end
  end
endmodule

// File: rtl/seq_event_logger.sv
// Timestamps detector pulses with their history snapshot and queues them on a
// valid/ready read port; keeps saturating event/drop counters.
module seq_event_logger
  import seq_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int TS_W         = 11,
  parameter int CNT_W        = 8,
  parameter bit STOP_ON_FULL = 1'b0
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_arm,
  input  logic                   i_clr,
  input  logic                   i_det,
  input  logic [HIST_W-1:0]      i_hist,
  output logic                   o_rd_valid,
  input  logic                   i_rd_ready,
  output logic [TS_W+HIST_W-1:0] o_rd_data,
  output logic [CNT_W-1:0]       o_evt_cnt,
  output logic [CNT_W-1:0]       o_drop_cnt,
  output logic                   o_overflow,
  output logic                   o_frozen
);
  localparam int EW = entry_w(TS_W);

  state_t           r_state;
  logic [TS_W-1:0]  r_ts;
  logic [CNT_W-1:0] r_evt, r_drop;
  logic             r_ovf;

  logic          w_empty, w_full, w_cap, w_pop, w_drop, w_push;
  logic [EW-1:0] w_din;

  // clr suppresses capture and pop in its cycle; the FIFO is flushed anyway
  assign w_cap  = (r_state == ST_RUN) & i_det & ~i_clr;
  assign w_pop  = ~w_empty & i_rd_ready & ~i_clr;
  assign w_drop = w_cap & w_full & ~w_pop;
  assign w_push = w_cap & ~w_drop;
  assign w_din  = {r_ts, i_hist};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_ts    <= '0;
      r_evt   <= '0;
      r_drop  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_ts <= r_ts + 1'b1;
      if (i_clr) begin
        r_state <= ST_IDLE;
        r_evt   <= '0;
        r_drop  <= '0;
        r_ovf   <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: if (i_arm) r_state <= ST_RUN;
          ST_RUN: begin
            if (w_drop && STOP_ON_FULL) r_state <= ST_FROZEN;
            else if (!i_arm)            r_state <= ST_IDLE;
          end
          ST_FROZEN: r_state <= ST_FROZEN;
          default:   r_state <= ST_IDLE;
        endcase
        if (w_cap && (r_evt != '1)) r_evt <= r_evt + 1'b1;
        if (w_drop) begin
          if (r_drop != '1) r_drop <= r_drop + 1'b1;
          r_ovf <= 1'b1;
        end
      end
    end
  end

  seq_sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (i_clr),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_dout  (o_rd_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign o_rd_valid = ~w_empty;
  assign o_evt_cnt  = r_evt;
  assign o_drop_cnt = r_drop;
  assign o_overflow = r_ovf;
  assign o_frozen   = (r_state == ST_FROZEN);
endmodule
